queue_rr_arbiter: RTL and testbench
===================================

Name: queue_rr_arbiter

Overview:
- Shares one cyclic queue (single command port: data_in, mode 1=write/0=read, en, registered data_out) among NUM_REQ requesters in the convolution accelerator, e.g. the input-fetch engines and the MAC array.
- Round-robin arbitration issues at most one queue command per cycle.
- Tracks occupancy itself and never issues a write when full or a read when empty.
- Returns read data to the requester that issued the read, with a fixed latency.

Parameters:
- WIDTH, 32, queue data width.
- DEPTH, 256, queue capacity in entries. Must match the queue instance.
- NUM_REQ, 4, number of requesters, 2..8.
- CNT_W, $clog2(DEPTH+1), occupancy counter width.
- ID_W, $clog2(NUM_REQ), requester index width.

Ports:
- clk  in  1  clock. Rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  NUM_REQ  per-requester request. Held until granted.
- req_wr  in  NUM_REQ  per-requester op: 1=write, 0=read. Stable while req is high.
- req_wdata  in  NUM_REQ*WIDTH  per-requester write data, packed by index.
- gnt  out  NUM_REQ  one-hot grant, combinational, same cycle as the winning request.
- rd_valid  out  NUM_REQ  one-hot read-return strobe, one cycle.
- rd_data  out  WIDTH  read-return data, shared bus.
- q_en  out  1  queue enable, registered.
- q_mode  out  1  queue mode, registered.
- q_data_in  out  WIDTH  queue write data, registered.
- q_data_out  in  WIDTH  queue read data, valid the cycle after the queue's read edge.
- count  out  CNT_W  current occupancy.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.

Behaviour:
- Reset (rst low, asynchronous): gnt=0, rd_valid=0, rd_data=0, q_en=0, q_mode=0, q_data_in=0, count=0, rr pointer=0, return pipeline cleared. full=0, empty=1.
- Eligibility in cycle T: eligible[i] = req[i] & (req_wr[i] ? !full : !empty). Ineligible requests wait without a grant. They are not dropped.
- Arbitration: the first eligible index at or after the rr pointer, searching upward and wrapping, wins. gnt is one-hot for that index, or all zero if none is eligible.
- Pointer update: on a grant to index k, the pointer becomes (k+1) mod NUM_REQ at the edge ending T. With no grant, the pointer holds.
- Command issue: at the edge ending T, q_en<=|gnt, q_mode<=req_wr[k], q_data_in<=req_wdata[k]. With no grant, q_en<=0 and q_mode/q_data_in hold.
- The queue acts on the edge ending T+1.
- Occupancy: updated at the edge ending T. +1 on a granted write, -1 on a granted read, unchanged otherwise. full/empty are decoded from count, so a grant in T is reflected in eligibility in T+1. Back-to-back write then read of the last entry is legal.
- Read return: a 2-stage shift register carries {valid, id} of granted reads. In cycle T+2, rd_data=q_data_out and rd_valid[k]=1 for exactly one cycle. The registered rd_data holds its value otherwise.
- Latency: write grant -> queue write is 1 cycle. Read grant -> rd_valid is 2 cycles. Throughput is 1 op/cycle, and reads may be pipelined back to back.
- Boundaries:
  - Full: all writers stall. Readers are unaffected.
  - Empty: all readers stall.
  - count never exceeds DEPTH and never underflows.
  - Wrap-around of queue pointers is the queue's responsibility. The arbiter only counts.
- Reset mid-operation: in-flight reads are discarded (no rd_valid) and count returns to 0. The queue shares rst and is emptied coherently.
- Requester deasserting req before its grant is allowed; it is simply not served.

Decomposition:
- Shared package (accel_pkg): OP_READ=1'b0, OP_WRITE=1'b1, default WIDTH/DEPTH constants.
- One sub-module: rr_pick. Combinational: eligible vector + pointer -> one-hot grant + winner index.
- Counter, command register and return pipeline stay in the top.

Test Plan:
- Single writer: req0 writes 0xA5 -> gnt[0] same cycle; next cycle q_en=1, q_mode=1, q_data_in=0xA5; count 0->1.
- Round-robin fairness: req0..3 all write continuously, pointer 0 -> grants 0,1,2,3,0,... one per cycle; count increments each cycle.
- Read return ordering:
  - Stimulus: write 0x11 then 0x22, then req2 and req3 read back to back.
  - Required: rd_valid[2] with 0x11, then rd_valid[3] with 0x22, two cycles after each grant.
- Full/empty stalls:
  - Fill to DEPTH=256 -> full=1; a further write gets no gnt while a simultaneous read is granted.
  - Empty: a read gets no gnt and count stays 0.
- Reset mid-read: assert rst low one cycle after a read grant -> no rd_valid, count=0, empty=1, outputs at reset values.

Source files
------------

// File: rtl/accel_pkg.sv
// Shared accelerator definitions: queue op encodings and default sizes.
package accel_pkg;

  localparam logic OP_READ  = 1'b0;
  localparam logic OP_WRITE = 1'b1;

  localparam int DEF_WIDTH   = 32;
  localparam int DEF_DEPTH   = 256;
  localparam int DEF_NUM_REQ = 4;

endpackage

// File: rtl/queue_rr_arbiter_rr_pick.sv
// Round-robin pick: first eligible index at or after ptr, wrapping upward.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  eligible,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  logic found;
  int   j;

  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    j     = 0;
    for (int o = 0; o < N; o++) begin
      j = (int'(ptr) + o) % N;
      if (!found && eligible[j]) begin
        found  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IW'(j);
      end
    end
  end

endmodule

// File: rtl/queue_rr_arbiter.sv
// Round-robin arbiter sharing one cyclic queue command port among requesters,
// with occupancy tracking and fixed-latency read return.
import accel_pkg::*;

module queue_rr_arbiter #(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int NUM_REQ = DEF_NUM_REQ,
  parameter int CNT_W   = $clog2(DEPTH + 1),
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ-1:0]       req_wr,
  input  logic [NUM_REQ*WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       rd_valid,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     q_en,
  output logic                     q_mode,
  output logic [WIDTH-1:0]         q_data_in,
  input  logic [WIDTH-1:0]         q_data_out,
  output logic [CNT_W-1:0]         count,
  output logic                     full,
  output logic                     empty
);

  logic [NUM_REQ-1:0] elig;
  logic [WIDTH-1:0]   wdata [NUM_REQ];
  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    win;
  logic               any;
  logic               wr_sel;

  logic               s1_v;
  logic [ID_W-1:0]    s1_id;
  logic               s2_v;
  logic [ID_W-1:0]    s2_id;
  logic [WIDTH-1:0]   rd_hold;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);

  always_comb begin
    elig = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wdata[i] = req_wdata[i*WIDTH +: WIDTH];
      elig[i]  = req[i] & ((req_wr[i] == OP_WRITE) ? !full : !empty);
    end
  end

  rr_pick #(
    .N  (NUM_REQ),
    .IW (ID_W)
  ) u_pick (
    .eligible (elig),
    .ptr      (ptr),
    .gnt      (gnt),
    .idx      (win)
  );

  assign any    = |gnt;
  assign wr_sel = req_wr[win];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr       <= '0;
      q_en      <= 1'b0;
      q_mode    <= 1'b0;
      q_data_in <= '0;
      count     <= '0;
    end else begin
      q_en <= any;
      if (any) begin
        ptr       <= (win == ID_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
        q_mode    <= wr_sel;
        q_data_in <= wdata[win];
        if (wr_sel == OP_WRITE) count <= count + 1'b1;
        else                    count <= count - 1'b1;
      end
    end
  end

  // Read data leaves the queue the cycle after its read edge, two after grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_v    <= 1'b0;
      s1_id   <= '0;
      s2_v    <= 1'b0;
      s2_id   <= '0;
      rd_hold <= '0;
    end else begin
      s1_v  <= any && (wr_sel == OP_READ);
      s1_id <= win;
      s2_v  <= s1_v;
      s2_id <= s1_id;
      if (s2_v) rd_hold <= q_data_out;
    end
  end

  assign rd_valid = s2_v ? (NUM_REQ'(1) << s2_id) : '0;
  assign rd_data  = s2_v ? q_data_out : rd_hold;

endmodule

// File: tb/tb_queue_rr_arbiter.sv
// Directed bench for queue_rr_arbiter with a behavioural cyclic queue.
module tb_queue_rr_arbiter;

  localparam int WIDTH   = 32;
  localparam int DEPTH   = 256;
  localparam int NUM_REQ = 4;
  localparam int CNT_W   = 9;

  logic                     clk = 1'b0;
  logic                     rst = 1'b0;
  logic [NUM_REQ-1:0]       req = '0;
  logic [NUM_REQ-1:0]       req_wr = '0;
  logic [NUM_REQ*WIDTH-1:0] req_wdata = '0;
  logic [NUM_REQ-1:0]       gnt;
  logic [NUM_REQ-1:0]       rd_valid;
  logic [WIDTH-1:0]         rd_data;
  logic                     q_en;
  logic                     q_mode;
  logic [WIDTH-1:0]         q_data_in;
  logic [WIDTH-1:0]         q_data_out;
  logic [CNT_W-1:0]         count;
  logic                     full;
  logic                     empty;

  int npass = 0;
  int ntot  = 0;

  queue_rr_arbiter #(
    .WIDTH   (WIDTH),
    .DEPTH   (DEPTH),
    .NUM_REQ (NUM_REQ)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_wr     (req_wr),
    .req_wdata  (req_wdata),
    .gnt        (gnt),
    .rd_valid   (rd_valid),
    .rd_data    (rd_data),
    .q_en       (q_en),
    .q_mode     (q_mode),
    .q_data_in  (q_data_in),
    .q_data_out (q_data_out),
    .count      (count),
    .full       (full),
    .empty      (empty)
  );

  always #5 clk = ~clk;

  // Behavioural cyclic queue sharing the arbiter's reset.
  logic [WIDTH-1:0] mem [DEPTH];
  logic [7:0]       head;
  logic [7:0]       tail;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      head       <= '0;
      tail       <= '0;
      q_data_out <= '0;
    end else if (q_en) begin
      if (q_mode) begin
        mem[tail] <= q_data_in;
        tail      <= tail + 8'd1;
      end else begin
        q_data_out <= mem[head];
        head       <= head + 8'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    tick();
    tick();
    rst = 1'b1;
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_gnt", 64'(gnt), 64'h0);
    chk("rst_rd_valid", 64'(rd_valid), 64'h0);
    chk("rst_rd_data", 64'(rd_data), 64'h0);
    chk("rst_q_en", 64'(q_en), 64'h0);
    chk("rst_q_mode", 64'(q_mode), 64'h0);
    chk("rst_q_data_in", 64'(q_data_in), 64'h0);
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_full", 64'(full), 64'h0);
    chk("rst_empty", 64'(empty), 64'h1);
    tick();
    rst = 1'b1;

    // Read while empty stalls
    req = 4'b0010; req_wr = 4'b0000;
    #1 chk("empty_rd_gnt", 64'(gnt), 64'h0);
    tick();
    chk("empty_rd_q_en", 64'(q_en), 64'h0);
    chk("empty_rd_count", 64'(count), 64'h0);
    req = '0;

    // Single writer
    req = 4'b0001; req_wr = 4'b0001; req_wdata[31:0] = 32'hA5;
    #1 chk("sw_gnt", 64'(gnt), 64'h1);
    tick();
    req = '0;
    chk("sw_q_en", 64'(q_en), 64'h1);
    chk("sw_q_mode", 64'(q_mode), 64'h1);
    chk("sw_q_data_in", 64'(q_data_in), 64'hA5);
    chk("sw_count", 64'(count), 64'h1);
    chk("sw_empty", 64'(empty), 64'h0);

    // Round-robin fairness from pointer 0
    do_reset();
    req_wr = 4'b1111;
    for (int i = 0; i < NUM_REQ; i++) req_wdata[i*WIDTH +: WIDTH] = 32'h10 + i;
    req = 4'b1111;
    #1 chk("rr_gnt0", 64'(gnt), 64'h1);
    tick(); chk("rr_din0", 64'(q_data_in), 64'h10);
    chk("rr_cnt0", 64'(count), 64'd1);
    #1 chk("rr_gnt1", 64'(gnt), 64'h2);
    tick(); chk("rr_din1", 64'(q_data_in), 64'h11);
    chk("rr_cnt1", 64'(count), 64'd2);
    #1 chk("rr_gnt2", 64'(gnt), 64'h4);
    tick(); chk("rr_din2", 64'(q_data_in), 64'h12);
    chk("rr_cnt2", 64'(count), 64'd3);
    #1 chk("rr_gnt3", 64'(gnt), 64'h8);
    tick(); chk("rr_din3", 64'(q_data_in), 64'h13);
    chk("rr_cnt3", 64'(count), 64'd4);
    #1 chk("rr_gnt4", 64'(gnt), 64'h1);
    tick(); chk("rr_din4", 64'(q_data_in), 64'h10);
    chk("rr_cnt4", 64'(count), 64'd5);
    req = '0;

    // Read return ordering
    do_reset();
    req = 4'b0001; req_wr = 4'b0001; req_wdata[31:0] = 32'h11;
    tick();
    req = 4'b0010; req_wr = 4'b0010; req_wdata[63:32] = 32'h22;
    #1 chk("ro_wr2_gnt", 64'(gnt), 64'h2);
    tick();
    req = 4'b1100; req_wr = 4'b0000;
    #1 chk("ro_rd2_gnt", 64'(gnt), 64'h4);
    tick();
    req = 4'b1000;
    chk("ro_rv_t1", 64'(rd_valid), 64'h0);
    #1 chk("ro_rd3_gnt", 64'(gnt), 64'h8);
    tick();
    req = '0;
    chk("ro_rv2", 64'(rd_valid), 64'h4);
    chk("ro_rdata2", 64'(rd_data), 64'h11);
    tick();
    chk("ro_rv3", 64'(rd_valid), 64'h8);
    chk("ro_rdata3", 64'(rd_data), 64'h22);
    chk("ro_count", 64'(count), 64'h0);
    chk("ro_empty", 64'(empty), 64'h1);
    tick();
    chk("ro_rv_idle", 64'(rd_valid), 64'h0);
    chk("ro_rdata_hold", 64'(rd_data), 64'h22);

    // Fill to full; writer stalls while a reader is served
    req = 4'b0001; req_wr = 4'b0001; req_wdata[31:0] = 32'h5A;
    for (int i = 0; i < DEPTH; i++) tick();
    chk("full_count", 64'(count), 64'd256);
    chk("full_flag", 64'(full), 64'h1);
    chk("full_wr_gnt", 64'(gnt), 64'h0);
    req = 4'b0011; req_wr = 4'b0001;
    #1 chk("full_rd_gnt", 64'(gnt), 64'h2);
    tick();
    req = '0;
    chk("full_after_rd_cnt", 64'(count), 64'd255);
    chk("full_after_rd_flag", 64'(full), 64'h0);
    chk("full_after_rd_mode", 64'(q_mode), 64'h0);

    // Reset one cycle after a read grant
    req = 4'b0010; req_wr = 4'b0000;
    #1 chk("mr_gnt", 64'(gnt), 64'h2);
    tick();
    req = '0;
    rst = 1'b0;
    #1;
    chk("mr_rd_valid", 64'(rd_valid), 64'h0);
    chk("mr_count", 64'(count), 64'h0);
    chk("mr_empty", 64'(empty), 64'h1);
    chk("mr_q_en", 64'(q_en), 64'h0);
    chk("mr_q_data_in", 64'(q_data_in), 64'h0);
    chk("mr_rd_data", 64'(rd_data), 64'h0);
    tick();
    rst = 1'b1;
    tick();
    chk("mr_rd_valid_late1", 64'(rd_valid), 64'h0);
    tick();
    chk("mr_rd_valid_late2", 64'(rd_valid), 64'h0);
    chk("mr_count_late", 64'(count), 64'h0);

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
